inst_decode_stage: RTL

Decode stage between instruction fetch and `controlUnit`. It accepts a 32-bit SimpleRisc instruction word and its PC from fetch over a valid/ready handshake, registers it, and presents the decoded fields downstream: `opcode`, `iOrReg`, `modifier`, register indices, extended immediate, branch target and class flags. It flushes on branch redirect.

---
 rtl/decode_pkg.sv | 82 ++++++++
 rtl/decode_skid_buf.sv | 102 ++++++++++
 rtl/inst_decode_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, modifier encodings, field positions and the decoded-entry struct.
// Used by inst_decode_stage and decode_skid_buf (DECODE_SKID_EN selects the buffer depth).
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [1:0] MOD_S = 2'b00;
  localparam logic [1:0] MOD_U = 2'b01;
  localparam logic [1:0] MOD_H = 2'b10;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 27;
  localparam int IMM_BIT  = 26;
  localparam int RD_HI    = 25;
  localparam int RD_LO    = 22;
  localparam int RS1_HI   = 21;
  localparam int RS1_LO   = 18;
  localparam int RS2_HI   = 17;
  localparam int RS2_LO   = 14;
  localparam int MOD_HI   = 17;
  localparam int MOD_LO   = 16;
  localparam int IMM16_HI = 15;
  localparam int OFF_HI   = 26;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [4:0]      opcode;
    logic            iOrReg;
    logic [1:0]      modifier;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] brTarget;
    logic            isBranch;
    logic            isLd;
    logic            isSt;
    logic            isRet;
    logic            isWb;
    logic            illegal;
  } dec_t;

  // Modifier 11 is reserved and behaves like the default sign extension.
  function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm16,
                                                 input logic [1:0]  modifier);
    logic [XLEN-1:0] result;
    case (modifier)
      MOD_U:   result = {16'h0000, imm16};
      MOD_H:   result = {imm16, 16'h0000};
      default: result = {{16{imm16[15]}}, imm16};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Valid/ready storage for decoded entries: two-entry skid buffer with registered inRdy when
// DECODE_SKID_EN is defined, otherwise a single entry with combinational inRdy.
module decode_skid_buf
  import decode_pkg::*;
(
  input  logic clk,
  input  logic rstN,
  input  logic inValid,
  output logic inRdy,
  input  dec_t inData,
  input  logic flush,
  output logic outValid,
  input  logic outRdy,
  output dec_t outData
);

  buf_state_t state, nextState;
  dec_t       mainQ, mainD;
  logic       rdyQ;
  logic       inXfer;

`ifdef DECODE_SKID_EN
  dec_t skidQ, skidD;

  assign inRdy = rdyQ;
`else
  // rdyQ only keeps inRdy low until the first edge after reset.
  assign inRdy = rdyQ && (!outValid || outRdy);
`endif

  assign outValid = (state != EMPTY);
  assign outData  = mainQ;
  assign inXfer   = inValid && inRdy;

  always_comb begin
    nextState = state;
    mainD     = mainQ;
`ifdef DECODE_SKID_EN
    skidD     = skidQ;
`endif
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            nextState = ONE;
            mainD     = inData;
          end
        end
        ONE: begin
`ifdef DECODE_SKID_EN
          if (inXfer && outRdy) begin
            mainD = inData;
          end else if (inXfer) begin
            nextState = TWO;
            skidD     = inData;
          end else if (outRdy) begin
            nextState = EMPTY;
          end
`else
          if (inXfer) begin
            mainD = inData;
          end else if (outRdy) begin
            nextState = EMPTY;
          end
`endif
        end
`ifdef DECODE_SKID_EN
        TWO: begin
          if (outRdy) begin
            nextState = ONE;
            mainD     = skidQ;
          end
        end
`endif
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= EMPTY;
      mainQ <= '0;
      rdyQ  <= 1'b0;
`ifdef DECODE_SKID_EN
      skidQ <= '0;
`endif
    end else begin
      state <= nextState;
      mainQ <= mainD;
`ifdef DECODE_SKID_EN
      skidQ <= skidD;
      rdyQ  <= (nextState != TWO);
`else
      rdyQ  <= 1'b1;
`endif
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// SimpleRisc decode stage: combinational field decode of the fetched word, registered into
// decode_skid_buf so every output comes from a flop. DECODE_SKID_EN selects the two-entry buffer.
module inst_decode_stage
  import decode_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [3:0] RA_IDX = 4'd15
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inRdy,
  input  logic [31:0]       inInst,
  input  logic [DATA_W-1:0] inPc,
  input  logic              flush,
  output logic              outValid,
  input  logic              outRdy,
  output logic [4:0]        opcode,
  output logic              iOrReg,
  output logic [1:0]        modifier,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] brTarget,
  output logic              isBranch,
  output logic              isLd,
  output logic              isSt,
  output logic              isRet,
  output logic              isWb,
  output logic              illegal
);

  dec_t       decIn;
  dec_t       decOut;
  logic [4:0] op;

  assign op = inInst[OP_HI:OP_LO];

  always_comb begin
    decIn          = '0;
    decIn.opcode   = op;
    decIn.iOrReg   = inInst[IMM_BIT];
    decIn.modifier = inInst[MOD_HI:MOD_LO];
    decIn.rd       = inInst[RD_HI:RD_LO];
    decIn.rs1      = inInst[RS1_HI:RS1_LO];
    decIn.rs2      = inInst[RS2_HI:RS2_LO];
    decIn.imm      = extend_imm(inInst[IMM16_HI:0], inInst[MOD_HI:MOD_LO]);
    // Word offset, sign-extended and scaled to bytes; the add wraps silently.
    decIn.brTarget = inPc + {{3{inInst[OFF_HI]}}, inInst[OFF_HI:0], 2'b00};

    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_NOT, OP_MOV,
      OP_LSL, OP_LSR, OP_ASR: begin
        decIn.isWb = 1'b1;
      end
      OP_LD: begin
        decIn.isLd = 1'b1;
        decIn.isWb = 1'b1;
      end
      OP_ST: begin
        decIn.isSt = 1'b1;
        decIn.rs2  = inInst[RD_HI:RD_LO];
      end
      OP_BEQ, OP_BGT, OP_B: begin
        decIn.isBranch = 1'b1;
      end
      OP_CALL: begin
        decIn.isBranch = 1'b1;
        decIn.isWb     = 1'b1;
        decIn.rd       = RA_IDX;
      end
      OP_RET: begin
        decIn.isBranch = 1'b1;
        decIn.isRet    = 1'b1;
        decIn.rs1      = RA_IDX;
      end
      OP_CMP, OP_NOP: begin
      end
      default: begin
        decIn.illegal = 1'b1;
        decIn.opcode  = OP_NOP;
      end
    endcase
  end

  decode_skid_buf u_buf (
    .clk      (clk),
    .rstN     (rstN),
    .inValid  (inValid),
    .inRdy    (inRdy),
    .inData   (decIn),
    .flush    (flush),
    .outValid (outValid),
    .outRdy   (outRdy),
    .outData  (decOut)
  );

  assign opcode   = decOut.opcode;
  assign iOrReg   = decOut.iOrReg;
  assign modifier = decOut.modifier;
  assign rd       = decOut.rd;
  assign rs1      = decOut.rs1;
  assign rs2      = decOut.rs2;
  assign imm      = decOut.imm;
  assign brTarget = decOut.brTarget;
  assign isBranch = decOut.isBranch;
  assign isLd     = decOut.isLd;
  assign isSt     = decOut.isSt;
  assign isRet    = decOut.isRet;
  assign isWb     = decOut.isWb;
  assign illegal  = decOut.illegal;

endmodule
